// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: emulates the OV7670 parallel pixel bus from CLOCK_50 with
// synthetic 8-bit grayscale test patterns. This lets the capture path be
// exercised without a sensor.
//
// Ports:
//   CLOCK_50   in   system clock, all state on posedge
//   reset      in   asynchronous, active-high
//   enable     in   run request, sampled only at frame boundaries
//   pattern    in   0=h-ramp 1=checker 2=frame-count flat 3=v-ramp, latched at frame start
//   pclk       out  free-running pixel clock
//   vsync      out  high during the first VS_LINES lines of a running frame
//   href       out  high for active bytes of active lines
//   data       out  pixel byte, 0 whenever href=0
//   frame_done out  one CLOCK_50-cycle pulse at the end of each frame
//   busy       out  high while a frame is being emitted
module ov7670_stream_gen #(
    parameter int unsigned PCLK_DIV = 1,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_TOTAL  = 784,
    parameter int unsigned VS_LINES = 3,
    parameter int unsigned V_START  = 17,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_TOTAL  = 510
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] pattern,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int unsigned H_W   = $clog2(H_TOTAL + 1);
    localparam int unsigned V_W   = $clog2(V_TOTAL + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT    = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_VS     = V_W'(VS_LINES);
    localparam logic [V_W-1:0]   V_ST     = V_W'(V_START);
    localparam logic [V_W-1:0]   V_END    = V_W'(V_START + V_ACTIVE);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_cnt;
    logic [H_W-1:0]   h, h_d;
    logic [V_W-1:0]   v, v_d;
    logic [1:0]       pat_q, pat_d;
    logic [7:0]       frame_cnt, frame_cnt_d;
    logic             vsync_d, href_d, frame_done_d, busy_d;
    logic [7:0]       data_d;

    logic             div_wrap;
    logic             fall_tick;
    logic             emit;
    logic             act;
    logic [1:0]       pat_sel;
    logic [7:0]       x8, y8, pix;

    // pclk divider; a fall tick is the cycle on which pclk goes 1->0
    assign div_wrap  = (div_cnt == DIV_LAST);
    assign fall_tick = div_wrap & pclk;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            pclk    <= ~pclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Pixel generation for the current (h, v); the entry tick uses the live pattern
    always_comb begin
        act     = (v >= V_ST) && (v < V_END) && (h < H_ACT);
        pat_sel = (state == IDLE) ? pattern : pat_q;
        x8      = 8'(h);
        y8      = 8'(v - V_ST);
        case (pat_sel)
            2'd0:    pix = x8;
            2'd1:    pix = (x8[5] ^ y8[5]) ? 8'hFF : 8'h00;
            2'd2:    pix = frame_cnt;
            default: pix = y8;
        endcase
    end

    // Next-state and registered-output logic; everything advances on fall ticks only
    always_comb begin
        state_d      = state;
        h_d          = h;
        v_d          = v;
        pat_d        = pat_q;
        frame_cnt_d  = frame_cnt;
        vsync_d      = vsync;
        href_d       = href;
        data_d       = data;
        frame_done_d = 1'b0;
        emit         = 1'b0;

        if (fall_tick) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_d = RUN;
                        pat_d   = pattern;
                        emit    = 1'b1;
                    end
                end
                RUN: begin
                    emit = 1'b1;
                end
            endcase

            if (emit) begin
                vsync_d = (v < V_VS);
                href_d  = act;
                data_d  = act ? pix : 8'h00;
                if (h == H_LAST) begin
                    h_d = '0;
                    if (v == V_LAST) begin
                        // frame end: counters return to the origin, so IDLE always holds h=v=0
                        v_d          = '0;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt + 8'd1;
                        pat_d        = pattern;
                        if (!enable) begin
                            state_d = IDLE;
                        end
                    end else begin
                        v_d = v + V_W'(1);
                    end
                end else begin
                    h_d = h + H_W'(1);
                end
            end else begin
                vsync_d = 1'b0;
                href_d  = 1'b0;
                data_d  = 8'h00;
            end
        end

        busy_d = (state_d == RUN);
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            h          <= '0;
            v          <= '0;
            pat_q      <= 2'd0;
            frame_cnt  <= 8'd0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            h          <= h_d;
            v          <= v_d;
            pat_q      <= pat_d;
            frame_cnt  <= frame_cnt_d;
            vsync      <= vsync_d;
            href       <= href_d;
            data       <= data_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen: scoreboard bench for ov7670_stream_gen with small frame geometry.
// Expected active bytes are queued when a frame is requested and popped on each pclk rise.
module tb_ov7670_stream_gen;

    localparam int unsigned PCLK_DIV  = 1;
    localparam int unsigned H_ACTIVE  = 8;
    localparam int unsigned H_TOTAL   = 12;
    localparam int unsigned VS_LINES  = 1;
    localparam int unsigned V_START   = 2;
    localparam int unsigned V_ACTIVE  = 4;
    localparam int unsigned V_TOTAL   = 7;
    localparam int unsigned FRAME_CYC = 2 * PCLK_DIV * H_TOTAL * V_TOTAL;
    localparam int unsigned VS_RISES  = VS_LINES * H_TOTAL;
    localparam int unsigned ACT_BYTES = H_ACTIVE * V_ACTIVE;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] pattern;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;
    logic       frame_done;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;

    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         vs_cnt = 0;
    int         hr_cnt = 0;
    int         last_vs = 0;
    int         last_hr = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    int         prev_done_cyc = 0;
    logic       pclk_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    ov7670_stream_gen #(
        .PCLK_DIV (PCLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .VS_LINES (VS_LINES),
        .V_START  (V_START),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .enable     (enable),
        .pattern    (pattern),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] model_pix(input int p, input int x, input int y, input int fc);
        logic [7:0] xb;
        logic [7:0] yb;
        xb = 8'(x);
        yb = 8'(y);
        case (p)
            0:       return xb;
            1:       return (xb[5] ^ yb[5]) ? 8'hFF : 8'h00;
            2:       return 8'(fc);
            default: return yb;
        endcase
    endfunction

    task automatic push_frame(input int p, input int fc);
        for (int y = 0; y < int'(V_ACTIVE); y++)
            for (int x = 0; x < int'(H_ACTIVE); x++)
                exp_q.push_back(model_pix(p, x, y, fc));
    endtask

    // One CLOCK_50 cycle sampled at the falling edge, acting as the receiver model
    task automatic tick();
        logic [7:0] exp;
        @(negedge CLOCK_50);
        cyc++;
        if (reset) begin
            vs_cnt = 0;
            hr_cnt = 0;
        end else if (pclk && !pclk_prev) begin
            if (vsync) vs_cnt++;
            if (href) begin
                hr_cnt++;
                n_checks++;
                if (data !== data_prev) begin
                    n_fail++;
                    $display("FAIL stability: data %h at rise, %h one cycle before", data, data_prev);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: byte %h captured with nothing expected", data);
                end else begin
                    exp = exp_q.pop_front();
                    if (data !== exp) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h expected %h (cycle %0d)", data, exp, cyc);
                    end
                end
            end else begin
                n_checks++;
                if (data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL blank_data: got %h expected 00 with href=0", data);
                end
            end
        end
        if (frame_done) begin
            last_vs       = vs_cnt;
            last_hr       = hr_cnt;
            vs_cnt        = 0;
            hr_cnt        = 0;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            done_cnt++;
        end
        pclk_prev = pclk;
        data_prev = data;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic pp;
        int   d0;
        reset   = 1'b1;
        enable  = 1'b0;
        pattern = 2'd0;
        repeat (3) tick();
        n_checks++;
        if ({pclk, vsync, href, data, frame_done, busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected all zero", {pclk, vsync, href, data, frame_done, busy});
        end
        reset = 1'b0;
        pp = pclk;
        d0 = done_cnt;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_checks++;
            if (pclk === pp) begin
                n_fail++;
                $display("FAIL pclk_toggle: pclk stuck at %b in cycle %0d", pclk, i);
            end
            pp = pclk;
            n_checks++;
            if ({vsync, href, data, busy} !== 11'd0) begin
                n_fail++;
                $display("FAIL idle_outputs: got %b expected zero", {vsync, href, data, busy});
            end
        end
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL idle_frame_done: %0d pulses, expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_hramp();
        bit ok;
        pattern = 2'd0;
        push_frame(0, 0);
        enable = 1'b1;
        wait_done(400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL hramp_timeout: no frame_done, expected one"); end
        n_checks++;
        if (last_vs != int'(VS_RISES)) begin
            n_fail++; $display("FAIL vsync_len: %0d pclk, expected %0d", last_vs, VS_RISES);
        end
        n_checks++;
        if (last_hr != int'(ACT_BYTES)) begin
            n_fail++; $display("FAIL href_bytes: %0d, expected %0d", last_hr, ACT_BYTES);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL hramp_left: %0d bytes not seen, expected 0", exp_q.size());
        end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_run: got %b expected 1", busy); end
        push_frame(0, 1);
        wait_done(400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL hramp_timeout2: no frame_done, expected one"); end
        n_checks++;
        if (last_done_cyc - prev_done_cyc != int'(FRAME_CYC)) begin
            n_fail++;
            $display("FAIL frame_period: %0d cycles, expected %0d", last_done_cyc - prev_done_cyc, FRAME_CYC);
        end
        n_checks++;
        if (last_hr != int'(ACT_BYTES) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL hramp_frame2: %0d bytes, %0d left, expected %0d and 0", last_hr, exp_q.size(), ACT_BYTES);
        end
    endtask

    task automatic test_frame_count();
        bit ok;
        enable  = 1'b0;
        pattern = 2'd2;
        reset   = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        push_frame(2, 0);
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            push_frame(2, f + 1);
            wait_done(400, ok);
            n_checks++;
            if (!ok || last_hr != int'(ACT_BYTES)) begin
                n_fail++;
                $display("FAIL fc_frame%0d: done=%0d bytes=%0d expected done=1 bytes=%0d", f, ok, last_hr, ACT_BYTES);
            end
        end
        // frame 2 (count 2) is running; a pattern change now belongs to frame 3
        repeat (60) tick();
        pattern = 2'd1;
        push_frame(1, 3);
        wait_done(400, ok);
        n_checks++;
        if (!ok || exp_q.size() != int'(ACT_BYTES)) begin
            n_fail++;
            $display("FAIL fc_mid_switch: done=%0d left=%0d expected done=1 left=%0d", ok, exp_q.size(), ACT_BYTES);
        end
        repeat (60) tick();
        pattern = 2'd3;
        push_frame(3, 4);
        wait_done(400, ok);
        wait_done(400, ok);
        n_checks++;
        if (!ok || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fc_vramp: done=%0d left=%0d expected done=1 left=0", ok, exp_q.size());
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int d0;
        push_frame(3, 5);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (hr_cnt >= int'(H_ACTIVE)) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drop_reach_line3: hr_cnt=%0d expected >=%0d", hr_cnt, H_ACTIVE); end
        enable = 1'b0;
        wait_done(400, ok);
        n_checks++;
        if (!ok || last_hr != int'(ACT_BYTES) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drop_complete: done=%0d bytes=%0d left=%0d expected 1/%0d/0", ok, last_hr, exp_q.size(), ACT_BYTES);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b expected 0", busy); end
        d0 = done_cnt;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_checks++;
            if ({vsync, href, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL drop_idle: vsync/href/busy=%b expected 000", {vsync, href, busy});
            end
        end
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL drop_no_frame: %0d pulses expected 0", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        logic pp;
        pattern = 2'd0;
        push_frame(0, 0);
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (href === 1'b1 && hr_cnt >= 3) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_reach_href: hr_cnt=%0d expected >=3", hr_cnt); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({vsync, href, data, busy, frame_done} !== 12'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %b expected zero", {vsync, href, data, busy, frame_done});
        end
        exp_q.delete();
        repeat (3) tick();
        reset = 1'b0;
        push_frame(0, 0);
        pp = pclk;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pclk && !pp && busy) begin ok = 1'b1; break; end
            pp = pclk;
        end
        n_checks++;
        if (!ok || vsync !== 1'b1 || href !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_first_line: found=%0d vsync=%b href=%b expected 1/1/0", ok, vsync, href);
        end
        enable = 1'b0;
        wait_done(400, ok);
        n_checks++;
        if (!ok || last_vs != int'(VS_RISES) || last_hr != int'(ACT_BYTES) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_clean_frame: done=%0d vs=%0d bytes=%0d left=%0d expected 1/%0d/%0d/0",
                     ok, last_vs, last_hr, exp_q.size(), VS_RISES, ACT_BYTES);
        end
        repeat (10) tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_end_busy: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_hramp();
        test_frame_count();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
